paced_sample_queue: RTL and testbench

Buffers ADC samples arriving on a valid/ready stream and releases them at a fixed programmable rate, one frame of CHANNELS samples per rate tick. It sits between the ADC capture logic and the pitch-shift datapath, replacing ad-hoc per-sample rate counters. It generalises sample width, queue depth, channel count and output period, and adds underrun and missed-tick reporting.

---
 rtl/paced_sample_queue.sv | 137 +++++++++++++
 tb/tb_paced_sample_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paced_sample_queue.sv
// Sample FIFO drained at a programmable tick rate, one CHANNELS-sample frame per tick.
// Flags ticks that find too little data (underrun) or land mid-frame (tick_missed).
module paced_sample_queue #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 1,
    parameter int PERIOD_W = 12,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CW-1:0]       out_chan,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LW-1:0]       level,
    output logic                underrun,
    output logic                tick_missed,
    output logic [15:0]         underrun_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic                underrun_q, underrun_d;
    logic                tick_missed_q, tick_missed_d;
    logic [15:0]         ucnt_q, ucnt_d;
    logic [WIDTH:0]      mem_q [DEPTH];

    logic full, push, pop, tick;

    // No bypass: a full queue refuses input even while it is being popped.
    assign full     = (level_q == LW'(DEPTH));
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == EMIT) && out_ready;
    assign tick     = enable && (cnt_q >= period);

    always_comb begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (!enable || tick) cnt_d = '0;
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        underrun_d    = 1'b0;
        tick_missed_d = 1'b0;
        ucnt_d        = ucnt_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (level_q >= LW'(CHANNELS)) begin
                        state_d = EMIT;
                        chan_d  = '0;
                    end else begin
                        underrun_d = 1'b1;
                        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                    end
                end
            end
            EMIT: begin
                tick_missed_d = tick;
                if (out_ready) begin
                    if (chan_q == CW'(CHANNELS - 1)) begin
                        state_d = IDLE;
                        chan_d  = '0;
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            cnt_q         <= '0;
            chan_q        <= '0;
            underrun_q    <= 1'b0;
            tick_missed_q <= 1'b0;
            ucnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            chan_q        <= chan_d;
            underrun_q    <= underrun_d;
            tick_missed_q <= tick_missed_d;
            ucnt_q        <= ucnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage is not reset; contents are only visible behind out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    assign out_valid      = (state_q == EMIT);
    assign out_data       = out_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign out_last       = out_valid ? mem_q[rd_ptr_q][WIDTH] : 1'b0;
    assign out_chan       = chan_q;
    assign level          = level_q;
    assign underrun       = underrun_q;
    assign tick_missed    = tick_missed_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_paced_sample_queue.sv
// Scoreboard bench: stimulus queues expected samples, negedge monitors pop and compare.
module tb_paced_sample_queue;
    logic        clk = 1'b0;
    logic        reset;
    // single-channel instance
    logic        enable, in_last, in_valid, in_ready, out_last, out_valid, out_ready;
    logic        underrun, tick_missed, out_chan;
    logic [11:0] period, in_data, out_data;
    logic [4:0]  level;
    logic [15:0] underrun_count;
    // two-channel instance
    logic        enable2, in_last2, in_valid2, in_ready2, out_last2, out_valid2, out_ready2;
    logic        underrun2, tick_missed2, out_chan2;
    logic [11:0] period2, in_data2, out_data2;
    logic [4:0]  level2;
    logic [15:0] underrun_count2;

    typedef struct {
        logic [11:0] d;
        logic        l;
        logic        c;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last1 = -1;
    int   last2 = -1;
    bit   gap_chk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    paced_sample_queue dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .underrun(underrun), .tick_missed(tick_missed), .underrun_count(underrun_count)
    );

    paced_sample_queue #(.CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .period(period2),
        .in_data(in_data2), .in_last(in_last2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_chan(out_chan2), .out_last(out_last2),
        .out_valid(out_valid2), .out_ready(out_ready2), .level(level2),
        .underrun(underrun2), .tick_missed(tick_missed2), .underrun_count(underrun_count2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_out_data", 32'(out_data), 32'(e.d));
                chk("dut1_out_last", 32'(out_last), 32'(e.l));
                chk("dut1_out_chan", 32'(out_chan), 32'(e.c));
                if (gap_chk && last1 >= 0) chk("dut1_tick_gap", 32'(cyc - last1), 32'd4);
            end
            last1 = cyc;
        end
        if (!reset && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_output", 32'(out_data2), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_out_data", 32'(out_data2), 32'(e.d));
                chk("dut2_out_chan", 32'(out_chan2), 32'(e.c));
                if (e.c == 1'b1) chk("dut2_frame_consecutive", 32'(cyc - last2), 32'd1);
            end
            last2 = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [11:0] d, input logic l);
        int k = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && k < 50) begin step(1); k++; end
        chk("push1_ready", 32'(in_ready), 32'd1);
        q1.push_back('{d, l, 1'b0});
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic push2(input logic [11:0] d, input logic c);
        int k = 0;
        in_data2 = d; in_last2 = 1'b0; in_valid2 = 1'b1;
        while (!in_ready2 && k < 50) begin step(1); k++; end
        chk("push2_ready", 32'(in_ready2), 32'd1);
        q2.push_back('{d, 1'b0, c});
        step(1);
        in_valid2 = 1'b0;
    endtask

    task automatic wait_valid1(input string nm);
        int k = 0;
        while (!out_valid && k < 40) begin step(1); k++; end
        chk(nm, 32'(out_valid), 32'd1);
    endtask

    task automatic drain1(input string nm);
        int k = 0;
        while ((level != 0 || out_valid) && k < 200) begin step(1); k++; end
        enable = 1'b0;
        chk(nm, 32'(level), 32'd0);
    endtask

    initial begin
        int acc;
        int k;
        reset = 1'b1;
        enable = 0; period = 12'd3; in_data = 0; in_last = 0; in_valid = 0; out_ready = 1;
        enable2 = 0; period2 = 12'd9; in_data2 = 0; in_last2 = 0; in_valid2 = 0; out_ready2 = 1;
        step(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_underrun_count", 32'(underrun_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        step(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1: paced release, one sample every 4 cycles
        for (int i = 1; i <= 8; i++) push1(12'(i), 1'b0);
        chk("t1_level_peak", 32'(level), 32'd8);
        gap_chk = 1'b1; last1 = -1;
        enable = 1'b1;
        step(40);
        chk("t1_level_empty", 32'(level), 32'd0);
        enable = 1'b0; gap_chk = 1'b0;
        step(2);

        // 2: fill to full with no draining, then drain
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 12'(32'h100 + acc);
            if (in_ready) begin q1.push_back('{in_data, 1'b0, 1'b0}); acc++; end
            step(1);
        end
        chk("t2_accepts", 32'(acc), 32'd16);
        chk("t2_level_full", 32'(level), 32'd16);
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        period = 12'd0; out_ready = 1'b1; enable = 1'b1;
        wait_valid1("t2_first_valid");
        chk("t2_no_bypass", 32'(in_ready), 32'd0);
        step(1);
        chk("t2_in_ready_after_pop", 32'(in_ready), 32'd1);
        chk("t2_level_after_pop", 32'(level), 32'd15);
        q1.push_back('{in_data, 1'b0, 1'b0});
        step(1);
        in_valid = 1'b0;
        drain1("t2_drained");
        step(2);

        // 3: two-channel frames, underrun then full frame
        push2(12'h201, 1'b0);
        enable2 = 1'b1;
        k = 0;
        while (!underrun2 && k < 20) begin step(1); k++; end
        chk("t3_underrun_pulse", 32'(underrun2), 32'd1);
        chk("t3_underrun_count", 32'(underrun_count2), 32'd1);
        chk("t3_level_kept", 32'(level2), 32'd1);
        step(1);
        chk("t3_underrun_one_cycle", 32'(underrun2), 32'd0);
        push2(12'h202, 1'b1);
        k = 0;
        while (!out_valid2 && k < 20) begin step(1); k++; end
        chk("t3_frame_start", 32'(out_valid2), 32'd1);
        step(3);
        enable2 = 1'b0;
        chk("t3_level2_empty", 32'(level2), 32'd0);

        // 4: stalled EMIT with a tick every cycle
        out_ready = 1'b0; period = 12'd0;
        push1(12'h401, 1'b0); push1(12'h402, 1'b0); push1(12'h403, 1'b0);
        enable = 1'b1;
        wait_valid1("t4_valid");
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_tick_missed", 32'(tick_missed), 32'd1);
            chk("t4_data_stable", 32'(out_data), 32'h401);
        end
        out_ready = 1'b1;
        drain1("t4_drained");
        step(2);

        // 5: reset in the middle of a frame
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push1(12'(32'h500 + i), 1'b0);
        enable = 1'b1;
        wait_valid1("t5_valid");
        chk("t5_level6", 32'(level), 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_out_valid", 32'(out_valid), 32'd0);
        chk("t5_async_out_data", 32'(out_data), 32'd0);
        chk("t5_async_in_ready", 32'(in_ready), 32'd0);
        chk("t5_async_level", 32'(level), 32'd0);
        chk("t5_async_tick_missed", 32'(tick_missed), 32'd0);
        chk("t5_async_ucount", 32'(underrun_count), 32'd0);
        q1.delete();
        step(1);
        reset = 1'b0; enable = 1'b0; out_ready = 1'b1;
        step(1);
        chk("t5_level_after", 32'(level), 32'd0);
        chk("t5_in_ready_after", 32'(in_ready), 32'd1);
        chk("t5_no_output", 32'(out_valid), 32'd0);

        // 6: underrun counter saturation, then last-flag carry
        period = 12'd0; enable = 1'b1;
        step(65534);
        chk("t6_count_fffe", 32'(underrun_count), 32'hFFFE);
        chk("t6_underrun_pulsing", 32'(underrun), 32'd1);
        step(6);
        chk("t6_count_sat", 32'(underrun_count), 32'hFFFF);
        enable = 1'b0;
        step(1);
        push1(12'h601, 1'b0); push1(12'h602, 1'b1); push1(12'h603, 1'b0);
        enable = 1'b1;
        drain1("t6_drained");
        chk("t6_count_held", 32'(underrun_count), 32'hFFFF);
        step(3);

        chk("sb1_empty", 32'(q1.size()), 32'd0);
        chk("sb2_empty", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
